serial_adder: RTL

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 17 +
 rtl/serial_adder_fa_cell.sv | 19 +
 rtl/serial_adder.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared declarations for the serial adder: the control FSM state type and
//   the helper that sizes the step counter.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to count 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// fa_cell
//   One-bit full adder, chained BPC times by serial_adder.
//   Ports:
//     a, b  - addend bits
//     cin   - carry in
//     s     - sum bit
//     co    - carry out
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ cin;
  assign co = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial adder/subtractor. It accepts one operation per valid/ready
//   handshake, processes BPC bits per clock over N = WIDTH/BPC clocks, and then
//   presents the result until the consumer takes it.
//   Parameters:
//     WIDTH - operand/result width (>= 2)
//     BPC   - bits processed per clock; WIDTH must be a multiple of BPC
//   Ports:
//     clk, rst_n          - clock (rising edge), asynchronous active-low reset
//     in_valid, in_ready  - operand handshake (in_ready only in IDLE)
//     a, b, cin, sub      - operands, carry-in (ignored for sub), 1 = a - b
//     out_valid,out_ready - result handshake (out_valid only in DONE)
//     sum, cout, ovf      - result, carry-out (sub: 1 = no borrow), overflow
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BPC   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / BPC;
  localparam int CW = cnt_width(N);

  state_t             state;
  state_t             state_next;
  logic [CW-1:0]      cnt;
  logic               carry;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [WIDTH-1:0]   acc;
  logic [BPC:0]       c;
  logic [BPC-1:0]     s_bits;
  logic [WIDTH+BPC-1:0] acc_wide;
  logic               last_step;

  // Carry chain over the BPC low bits of the operand registers.
  assign c[0] = carry;

  for (genvar i = 0; i < BPC; i++) begin : g_fa
    fa_cell u_fa (
      .a   (op_a[i]),
      .b   (op_b[i]),
      .cin (c[i]),
      .s   (s_bits[i]),
      .co  (c[i+1])
    );
  end

  // New sum bits enter at the MSB end; after N steps the result is aligned.
  assign acc_wide  = {s_bits, acc};
  assign last_step = (cnt == CW'(N - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (last_step) begin
          state_next = DONE;
        end else begin
          state_next = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end else begin
          state_next = DONE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Handshake flags are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE);
    end
  end

  // Operand capture, serial stepping and result latching.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a  <= {WIDTH{1'b0}};
      op_b  <= {WIDTH{1'b0}};
      acc   <= {WIDTH{1'b0}};
      carry <= 1'b0;
      cnt   <= {CW{1'b0}};
      sum   <= {WIDTH{1'b0}};
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtraction is a + ~b + 1: invert b and force the carry-in.
            op_a  <= a;
            op_b  <= b ^ {WIDTH{sub}};
            carry <= sub ? 1'b1 : cin;
            cnt   <= {CW{1'b0}};
          end else begin
            op_a  <= op_a;
            op_b  <= op_b;
            carry <= carry;
            cnt   <= cnt;
          end
        end
        RUN: begin
          op_a  <= op_a >> BPC;
          op_b  <= op_b >> BPC;
          acc   <= acc_wide[WIDTH+BPC-1:BPC];
          carry <= c[BPC];
          cnt   <= cnt + CW'(1'b1);
          if (last_step) begin
            // The top cell of the final chunk is bit WIDTH-1.
            sum  <= acc_wide[WIDTH+BPC-1:BPC];
            cout <= c[BPC];
            ovf  <= c[BPC] ^ c[BPC-1];
          end else begin
            sum  <= sum;
            cout <= cout;
            ovf  <= ovf;
          end
        end
        default: begin
          op_a  <= op_a;
          op_b  <= op_b;
          acc   <= acc;
          carry <= carry;
          cnt   <= cnt;
          sum   <= sum;
          cout  <= cout;
          ovf   <= ovf;
        end
      endcase
    end
  end

endmodule
